// File: rtl/step_ramp_pkg.sv
// step_ramp_pkg: ramp FSM encoding plus magnitude, sign and saturating helpers
package step_ramp_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    STOP   = 3'd4
  } ramp_state_t;
  // Wide enough that magnitude sums of COUNT_BITS-wide periods never wrap
  typedef logic [63:0] wide_t;
  function automatic wide_t mag(input wide_t x);
    return x[63] ? -x : x;
  endfunction
  function automatic wide_t with_sign(input wide_t m, input logic neg);
    return neg ? -m : m;
  endfunction
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input wide_t hi);
    return (a + b > hi) ? hi : a + b;
  endfunction
  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input wide_t lo);
    return (a < b || a - b < lo) ? lo : a - b;
  endfunction
endpackage

// File: rtl/step_ramp_controller_tick.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter with a one-cycle tick on terminal count
module tick_prescaler #(
  parameter int TICK_DIV = 53200
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/step_ramp_controller.sv
// step_ramp_controller: ramps the applied step period toward a host target on a fixed tick.
// Optional watchdog forced-stop: define STEP_RAMP_WATCHDOG_EN.
module step_ramp_controller
  import step_ramp_pkg::*;
#(
  parameter int COUNT_BITS   = 32,
  parameter int DELTA_BITS   = 16,
  parameter int TICK_DIV     = 53200,
  parameter int START_PERIOD = 200000,
`ifdef STEP_RAMP_WATCHDOG_EN
  parameter int WDOG_TICKS   = 500,
`endif
  parameter int MIN_PERIOD   = 2000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic signed [COUNT_BITS-1:0] cmd_period,
  input  logic        [DELTA_BITS-1:0] accel_delta,
  output logic signed [COUNT_BITS-1:0] out_period,
  output logic                         at_target,
  output logic        [2:0]            ramp_state,
  output logic                         wdog_trip
);
  localparam wide_t S  = wide_t'(START_PERIOD);
  localparam wide_t MN = wide_t'(MIN_PERIOD);
  function automatic wide_t sext(input logic [COUNT_BITS-1:0] x);
    return {{(64-COUNT_BITS){x[COUNT_BITS-1]}}, x};
  endfunction
  logic tick, rdy, pend_full, accept, expire, c_neg, t_neg, nxt_neg;
  logic signed [COUNT_BITS-1:0] pend, target, eff_tgt, clamped, nxt_out;
  wide_t m_in, c, t, d, nxt_mag;
  ramp_state_t state, nxt_state;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign cmd_ready  = rdy && !pend_full;
  assign accept     = cmd_valid && cmd_ready;
  assign m_in       = mag(sext(cmd_period));
  assign clamped    = COUNT_BITS'(with_sign((m_in != '0 && m_in < MN) ? MN : m_in, cmd_period[COUNT_BITS-1]));
  // A pending command is applied on the very tick that copies it into target
  assign eff_tgt    = expire ? '0 : pend_full ? pend : target;
  assign c          = mag(sext(out_period));
  assign t          = mag(sext(eff_tgt));
  assign c_neg      = out_period[COUNT_BITS-1];
  assign t_neg      = eff_tgt[COUNT_BITS-1];
  assign d          = accel_delta == '0 ? wide_t'(1) : wide_t'(accel_delta);
  assign nxt_out    = COUNT_BITS'(with_sign(nxt_mag, nxt_neg));
  assign at_target  = out_period == target;
  assign ramp_state = state;
  always_comb begin
    nxt_mag   = c;
    nxt_neg   = c_neg;
    nxt_state = state;
    if (c == '0) begin
      nxt_neg   = t_neg;
      nxt_mag   = t == '0 ? '0 : (t < S ? S : t);
      nxt_state = t == '0 ? IDLE : (nxt_mag > t ? ACCEL : CRUISE);
    end else if (t == '0 || c_neg != t_neg) begin
      // Slow down to the start point, then drop to zero for one tick
      nxt_mag   = c < S ? sat_add(c, d, S) : '0;
      nxt_state = c < S ? DECEL : STOP;
    end else if (c > t) begin
      nxt_mag   = sat_sub(c, d, t);
      nxt_state = ACCEL;
    end else if (c < t) begin
      nxt_mag   = sat_add(c, d, t);
      nxt_state = DECEL;
    end else nxt_state = CRUISE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdy        <= 1'b0;
      pend_full  <= 1'b0;
      pend       <= '0;
      target     <= '0;
      out_period <= '0;
      state      <= IDLE;
    end else begin
      rdy <= 1'b1;
      if (accept) begin
        pend      <= clamped;
        pend_full <= 1'b1;
      end else if (tick) pend_full <= 1'b0;
      if (tick) begin
        target     <= eff_tgt;
        out_period <= nxt_out;
        state      <= nxt_state;
      end
    end
`ifdef STEP_RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TICKS + 1);
  logic [WW-1:0] wcnt;
  logic          trip;
  assign expire    = tick && !accept && wcnt == WW'(WDOG_TICKS - 1);
  assign wdog_trip = trip;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt <= '0;
      trip <= 1'b0;
    end else if (accept) begin
      wcnt <= '0;
      trip <= 1'b0;
    end else if (tick && wcnt != WW'(WDOG_TICKS)) begin
      wcnt <= wcnt + WW'(1);
      if (expire) trip <= 1'b1;
    end
`else
  assign expire    = 1'b0;
  assign wdog_trip = 1'b0;
`endif
endmodule

// File: tb/tb_step_ramp_controller.sv
// tb_step_ramp_controller: table-driven per-tick checks plus back-pressure, reset and watchdog sequences
module tb_step_ramp_controller;
  localparam int TD = 4;
  localparam logic [2:0] IDLE = 3'd0, ACCEL = 3'd1, CRUISE = 3'd2, DECEL = 3'd3, STOP = 3'd4;
  typedef struct {
    logic       cmd;
    int         per;
    int         dlt;
    int         out;
    logic [2:0] st;
    logic       at;
    logic       trip;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready, at_target, wdog_trip;
  logic signed [31:0] cmd_period = '0;
  logic        [19:0] accel_delta = '0;
  logic signed [31:0] out_period;
  logic        [2:0]  ramp_state;
  int tests = 0, fails = 0, cyc = 0;
  vec_t tab[$];
  step_ramp_controller #(
    .COUNT_BITS(32), .DELTA_BITS(20), .TICK_DIV(TD), .START_PERIOD(200000),
`ifdef STEP_RAMP_WATCHDOG_EN
    .WDOG_TICKS(5),
`endif
    .MIN_PERIOD(2000)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .accel_delta(accel_delta), .out_period(out_period),
    .at_target(at_target), .ramp_state(ramp_state), .wdog_trip(wdog_trip)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic add(input logic c, input int p, input int dl, input int o,
                     input logic [2:0] s, input logic a, input logic tr);
    vec_t v;
    v.cmd = c; v.per = p; v.dlt = dl; v.out = o; v.st = s; v.at = a; v.trip = tr;
    tab.push_back(v);
  endtask
  task automatic send(input int p);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_period = p;
    chk("send_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic nxt();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % TD != 0);
  endtask
  task automatic run();
    foreach (tab[i]) begin
      accel_delta = 20'(tab[i].dlt);
      if (tab[i].cmd) send(tab[i].per);
      nxt();
      chk($sformatf("v%0d_out", i), $signed(out_period), tab[i].out);
      chk($sformatf("v%0d_state", i), ramp_state, tab[i].st);
      chk($sformatf("v%0d_at", i), at_target, tab[i].at);
      chk($sformatf("v%0d_trip", i), wdog_trip, tab[i].trip);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", $signed(out_period), 0);
    chk("rst_state", ramp_state, IDLE);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_trip", wdog_trip, 0);
    chk("rst_at", at_target, 1);
    rst = 1'b0;
    #1 chk("rel_ready_pre", cmd_ready, 0);
    @(posedge clk);
    #1 chk("rel_ready_post", cmd_ready, 1);
    add(1,  195000,   2500,  200000, ACCEL,  0, 0);
    add(0,       0,   2500,  197500, ACCEL,  0, 0);
    add(0,       0,   2500,  195000, ACCEL,  1, 0);
    add(0,       0,   2500,  195000, CRUISE, 1, 0);
    add(1,  190000,  50000,  190000, ACCEL,  1, 0);
    add(1,    1000,  50000,  140000, ACCEL,  0, 0);
    add(0,       0,  50000,   90000, ACCEL,  0, 0);
    add(1,    1000,  50000,   40000, ACCEL,  0, 0);
    add(0,       0,  50000,    2000, ACCEL,  1, 0);
    add(0,       0,  50000,    2000, CRUISE, 1, 0);
    add(1,   -2000, 100000,  102000, DECEL,  0, 0);
    add(0,       0, 100000,  200000, DECEL,  0, 0);
    add(0,       0, 100000,       0, STOP,   0, 0);
    add(0,       0, 100000, -200000, ACCEL,  0, 0);
    add(1,   -2000, 100000, -100000, ACCEL,  0, 0);
    add(0,       0, 100000,   -2000, ACCEL,  1, 0);
    add(0,       0, 100000,   -2000, CRUISE, 1, 0);
    add(1,       0, 100000, -102000, DECEL,  0, 0);
    add(0,       0, 100000, -200000, DECEL,  0, 0);
    add(0,       0, 100000,       0, STOP,   1, 0);
    add(0,       0, 100000,       0, IDLE,   1, 0);
    add(1,  250000, 100000,  250000, CRUISE, 1, 0);
    add(1,  300000, 100000,  300000, DECEL,  1, 0);
    add(0,       0, 100000,  300000, CRUISE, 1, 0);
    add(1, 1000000,      0,  300001, DECEL,  0, 0);
    add(1,  300000,      0,  300000, ACCEL,  1, 0);
    add(1,       0,      5,       0, STOP,   1, 0);
    add(0,       0,      5,       0, IDLE,   1, 0);
    add(1,    -500,  65000, -200000, ACCEL,  0, 0);
    add(0,       0,  65000, -135000, ACCEL,  0, 0);
    add(1,       0,  65000, -200000, DECEL,  0, 0);
    add(0,       0,  65000,       0, STOP,   1, 0);
    add(0,       0,  65000,       0, IDLE,   1, 0);
    run();
    // Back-pressure: second command must wait for the tick that consumes the first
    accel_delta = 20'd100000;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_period = 200000;
    chk("bp_first_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_period = 3000;
    chk("bp_busy", cmd_ready, 0);
    for (int n = 0; n < 8 && !cmd_ready; n++) @(negedge clk);
    chk("bp_ready_again", cmd_ready, 1);
    chk("bp_after_tick", cyc % TD, 0);
    chk("bp_first_out", $signed(out_period), 200000);
    chk("bp_first_state", ramp_state, CRUISE);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    nxt();
    chk("bp_second_out", $signed(out_period), 100000);
    chk("bp_second_state", ramp_state, ACCEL);
    // Asynchronous reset mid-ramp
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out", $signed(out_period), 0);
    chk("arst_state", ramp_state, IDLE);
    chk("arst_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_ready_pre", cmd_ready, 0);
    @(posedge clk);
    #1 chk("arst_ready_post", cmd_ready, 1);
`ifdef STEP_RAMP_WATCHDOG_EN
    tab.delete();
    add(1, 100000, 100000, 200000, ACCEL,  0, 0);
    add(0,      0, 100000, 100000, ACCEL,  1, 0);
    add(0,      0, 100000, 100000, CRUISE, 1, 0);
    add(0,      0, 100000, 100000, CRUISE, 1, 0);
    add(0,      0, 100000, 200000, DECEL,  0, 1);
    add(0,      0, 100000,      0, STOP,   1, 1);
    add(0,      0, 100000,      0, IDLE,   1, 1);
    run();
    send(100000);
    chk("wdog_clear", wdog_trip, 0);
`else
    nxt();
    chk("post_rst_idle_out", $signed(out_period), 0);
    chk("post_rst_idle_state", ramp_state, IDLE);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
